div_share_arbiter: RTL and testbench
====================================

// Module: div_share_arbiter
// PURPOSE
//  Shares one Div_mod_top_level divider among N_REQ requesters, one operation at a time.
//  Round-robin arbitration; latches the winner's operands and pulses the divider's valid_input.
//  Waits for valid_output, then returns the result to the winner with its index (ID).
//  Divide-by-zero is trapped locally and never reaches the divider.
// PARAMETERS
//  DATA_W      16    operand/result width (must match divider)
//  N_REQ       4     number of requesters (2..8)
//  ID_W        2     width of rsp_id, = clog2(N_REQ)
//  TIMEOUT_CYC 64    watchdog limit in WAIT state (used only with DIV_ARB_TIMEOUT_EN)
// PORTS
//  clk              in   1             system clock, rising edge
//  reset            in   1             synchronous, active-high
//  req_valid        in   N_REQ         bit i: requester i has an operation pending
//  req_ready        out  N_REQ         one-hot accept, combinational, IDLE only
//  req_dividend     in   N_REQ*DATA_W  requester i at bits [i*DATA_W +: DATA_W]
//  req_divisor      in   N_REQ*DATA_W  same packing
//  req_mode         in   N_REQ         0 = quotient, 1 = remainder
//  div_reset        out  1             to divider reset: reset | abort pulse
//  div_dividend     out  DATA_W        latched operand to divider
//  div_divisor      out  DATA_W        latched operand to divider
//  div_mode         out  1             latched mode to divider
//  div_valid_input  out  1             one-cycle start pulse to divider
//  div_valid_output in   1             divider result strobe
//  div_final_output in   DATA_W        divider result
//  rsp_valid        out  1             response pending; held until rsp_ready
//  rsp_ready        in   1             consumer accepts response
//  rsp_id           out  ID_W          requester index that owns the response
//  rsp_data         out  DATA_W        result
//  rsp_err          out  1             1 = divide-by-zero or timeout
//  busy             out  1             FSM not in IDLE
// BEHAVIOUR
//  Reset: FSM=IDLE, ptr=N_REQ-1 (so req 0 wins first), all outputs 0 (req_ready forced 0).
//  Reset mid-operation aborts everything; no response is issued for the in-flight op.
//  FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  IDLE: winner = first set req_valid bit searching ptr+1, ptr+2, ... (mod N_REQ).
//   req_ready = onehot(winner); the handshake completes in this cycle.
//   Latch operands, mode, id; ptr <= winner.
//   If latched divisor == 0: rsp_data=all ones, rsp_err=1, go to RESP (divider untouched).
//   Else go to ISSUE.
//  ISSUE: div_valid_input=1 for exactly one cycle; go to WAIT.
//  WAIT: on div_valid_output: rsp_data<=div_final_output, rsp_err<=0, go to RESP.
//  RESP: rsp_valid=1 with id/data/err stable; on rsp_ready go to IDLE (no new grant that cycle).
//  div_valid_output outside WAIT is ignored. req_valid is not sampled outside IDLE.
//  Throughput: at most one op in flight.
//  Latency: grant@T0, start pulse@T1; rsp_valid rises the cycle after the divider strobe.
//  Divide-by-zero: rsp_valid@T1.
//  div_* operands stay stable from ISSUE until the FSM leaves WAIT.
// CONFIGURATION
//  DIV_ARB_TIMEOUT_EN defined:
//   Counter clears on entry to WAIT and increments each WAIT cycle.
//   When it reaches TIMEOUT_CYC without a strobe: div_reset pulses 1 cycle,
//   rsp_data=0, rsp_err=1, go to RESP.
//  Not defined: WAIT blocks until strobe; div_reset == reset; no counter logic.
// TESTING
//  1. Req0 100/7 mode0, divider model lat 8
//     -> one div_valid_input pulse; rsp_id=0, rsp_data=14, rsp_err=0.
//  2. Req2 100/7 mode1 -> rsp_data=2, rsp_id=2; busy high from grant through the rsp handshake.
//  3. All 4 req_valid held high over 8 ops -> grant order 0,1,2,3,0,1,2,3; no requester starved.
//  4. Req1 divisor=0 -> no div_valid_input; rsp_err=1, rsp_data=16'hFFFF, rsp_valid the cycle after grant.
//  5. rsp_ready held low 5 cycles -> rsp_* stable; no new req_ready until accepted; a spurious strobe is ignored.
//  6. reset asserted in WAIT -> next cycle busy=0, rsp_valid=0, req 0 has priority.
//     With DIV_ARB_TIMEOUT_EN and a silent divider: rsp_err=1 after 64 WAIT cycles; div_reset pulses.

Source files
------------

// File: rtl/div_share_arbiter_if.sv
// Bundles the request, divider and response signals of div_share_arbiter.
// slave = arbiter view, master = environment (requesters, divider, consumer) view.
interface div_share_arbiter_if #(
   parameter int DATA_W = 16,
   parameter int N_REQ  = 4,
   parameter int ID_W   = 2
);
   // Handshakes: a transfer happens in a cycle where valid and ready are both 1;
   // valid never depends on ready, and payload is stable while valid waits for ready.
   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ-1:0]        req_ready;
   logic [N_REQ*DATA_W-1:0] req_dividend;
   logic [N_REQ*DATA_W-1:0] req_divisor;
   logic [N_REQ-1:0]        req_mode;

   logic                    div_reset;
   logic [DATA_W-1:0]       div_dividend;
   logic [DATA_W-1:0]       div_divisor;
   logic                    div_mode;
   logic                    div_valid_input;
   logic                    div_valid_output;
   logic [DATA_W-1:0]       div_final_output;

   logic                    rsp_valid;
   logic                    rsp_ready;
   logic [ID_W-1:0]         rsp_id;
   logic [DATA_W-1:0]       rsp_data;
   logic                    rsp_err;
   logic                    busy;
   logic [1:0]              fsm_state;

   modport slave (
      input  req_valid, req_dividend, req_divisor, req_mode,
      input  div_valid_output, div_final_output, rsp_ready,
      output req_ready, div_reset, div_dividend, div_divisor, div_mode, div_valid_input,
      output rsp_valid, rsp_id, rsp_data, rsp_err, busy, fsm_state
   );

   modport master (
      output req_valid, req_dividend, req_divisor, req_mode,
      output div_valid_output, div_final_output, rsp_ready,
      input  req_ready, div_reset, div_dividend, div_divisor, div_mode, div_valid_input,
      input  rsp_valid, rsp_id, rsp_data, rsp_err, busy, fsm_state
   );
endinterface

// File: rtl/div_share_arbiter.sv
// Round-robin sharing of one divider among N_REQ requesters, one operation at a time.
// Optional WAIT watchdog enabled by defining DIV_ARB_TIMEOUT_EN.
module div_share_arbiter #(
   parameter int DATA_W      = 16,
   parameter int N_REQ       = 4,
   parameter int ID_W        = 2,
   parameter int TIMEOUT_CYC = 64
) (
   input logic clk,
   input logic reset,
   div_share_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nx;
   logic [ID_W-1:0]   ptr;
   logic [ID_W-1:0]   win;
   logic [ID_W-1:0]   cand;
   logic              found;
   logic              grant;
   logic              timeout_hit;

   logic [DATA_W-1:0] dvd_arr [N_REQ];
   logic [DATA_W-1:0] dvs_arr [N_REQ];
   logic [DATA_W-1:0] sel_dividend;
   logic [DATA_W-1:0] sel_divisor;
   logic              sel_mode;

   logic [DATA_W-1:0] op_dividend;
   logic [DATA_W-1:0] op_divisor;
   logic              op_mode;
   logic [ID_W-1:0]   op_id;
   logic [DATA_W-1:0] rsp_data_q;
   logic              rsp_err_q;

   for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
      assign dvd_arr[i] = bus.req_dividend[i*DATA_W +: DATA_W];
      assign dvs_arr[i] = bus.req_divisor[i*DATA_W +: DATA_W];
   end

   // Search starts just after the last winner, so every pending requester is served within N_REQ grants.
   always_comb begin
      win   = '0;
      cand  = '0;
      found = 1'b0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = ID_W'((int'(ptr) + k) % N_REQ);
         if (!found && bus.req_valid[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   assign sel_dividend = dvd_arr[win];
   assign sel_divisor  = dvs_arr[win];
   assign sel_mode     = bus.req_mode[win];
   assign grant        = (state == S_IDLE) && found && !reset;

`ifdef DIV_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0] wait_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt <= '0;
      end else if (state == S_ISSUE) begin
         wait_cnt <= '0;
      end else if (state == S_WAIT) begin
         wait_cnt <= wait_cnt + CNT_W'(1);
      end
   end

   assign timeout_hit   = (state == S_WAIT) && !bus.div_valid_output &&
                          (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
   assign bus.div_reset = reset | timeout_hit;
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYC == 0);
   assign timeout_hit    = 1'b0;
   assign bus.div_reset  = reset;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (grant) state_nx = (sel_divisor == '0) ? S_RESP : S_ISSUE;
         S_ISSUE: state_nx = S_WAIT;
         S_WAIT:  if (bus.div_valid_output || timeout_hit) state_nx = S_RESP;
         S_RESP:  if (bus.rsp_ready) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready       = '0;
      bus.div_valid_input = 1'b0;
      bus.rsp_valid       = 1'b0;
      bus.busy            = (state != S_IDLE);
      case (state)
         S_IDLE:  if (grant) bus.req_ready[win] = 1'b1;
         S_ISSUE: bus.div_valid_input = 1'b1;
         S_RESP:  bus.rsp_valid = 1'b1;
         default: ;
      endcase
   end

   // A zero divisor is answered straight from IDLE; the divider never sees it.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr         <= ID_W'(N_REQ - 1);
         op_dividend <= '0;
         op_divisor  <= '0;
         op_mode     <= 1'b0;
         op_id       <= '0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         if (grant) begin
            op_dividend <= sel_dividend;
            op_divisor  <= sel_divisor;
            op_mode     <= sel_mode;
            op_id       <= win;
            ptr         <= win;
            if (sel_divisor == '0) begin
               rsp_data_q <= '1;
               rsp_err_q  <= 1'b1;
            end
         end
         if (state == S_WAIT) begin
            if (bus.div_valid_output) begin
               rsp_data_q <= bus.div_final_output;
               rsp_err_q  <= 1'b0;
            end else if (timeout_hit) begin
               rsp_data_q <= '0;
               rsp_err_q  <= 1'b1;
            end
         end
      end
   end

   assign bus.div_dividend = op_dividend;
   assign bus.div_divisor  = op_divisor;
   assign bus.div_mode     = op_mode;
   assign bus.rsp_id       = op_id;
   assign bus.rsp_data     = rsp_data_q;
   assign bus.rsp_err      = rsp_err_q;
   assign bus.fsm_state    = state;

endmodule

// File: tb/tb_div_share_arbiter.sv
// Directed bench for div_share_arbiter with a fixed-latency divider model.
// Define DIV_ARB_TIMEOUT_EN to also exercise the WAIT watchdog.
module tb_div_share_arbiter;
   localparam int LAT = 8;

   logic clk;
   logic reset;
   logic silent;
   logic spur;
   int   checks;
   int   errors;
   logic [18:0] exp_q[$];
   logic [15:0] t3_data [4] = '{16'd33, 16'd1, 16'd20, 16'd1};

   div_share_arbiter_if #(.DATA_W(16), .N_REQ(4), .ID_W(2)) bus ();

   div_share_arbiter #(.DATA_W(16), .N_REQ(4), .ID_W(2), .TIMEOUT_CYC(64)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Divider model: answers LAT cycles after the start pulse; spur injects a stray strobe.
   logic        dpend;
   int          dcnt;
   logic [15:0] dres;
   always @(posedge clk) begin
      bus.div_valid_output <= 1'b0;
      if (bus.div_reset) begin
         dpend <= 1'b0;
         dcnt  <= 0;
      end else if (bus.div_valid_input && !silent) begin
         dpend <= 1'b1;
         dcnt  <= LAT;
         dres  <= bus.div_mode ? (bus.div_dividend % bus.div_divisor)
                               : (bus.div_dividend / bus.div_divisor);
      end else if (dpend) begin
         if (dcnt == 1) begin
            bus.div_valid_output <= 1'b1;
            bus.div_final_output <= dres;
            dpend                <= 1'b0;
         end
         dcnt <= dcnt - 1;
      end
      if (spur) begin
         bus.div_valid_output <= 1'b1;
         bus.div_final_output <= 16'hBEEF;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b, input logic m);
      bus.req_dividend[i*16 +: 16] = a;
      bus.req_divisor[i*16 +: 16]  = b;
      bus.req_mode[i]              = m;
   endtask

   // Waits (bounded) for rsp_valid, then compares the response against the scoreboard head.
   task automatic finish_op(input string tag, input int exp_pulses);
      int n = 0;
      int pulses = 0;
      logic [18:0] e;
      while (!bus.rsp_valid && n < 200) begin
         if (bus.div_valid_input) pulses++;
         step();
         n++;
      end
      check({tag, "_rsp_seen"}, bus.rsp_valid, 1);
      check({tag, "_pulses"}, pulses, exp_pulses);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 19'h7FFFF;
      check({tag, "_rsp_err"}, bus.rsp_err, e[18]);
      check({tag, "_rsp_id"}, bus.rsp_id, e[17:16]);
      check({tag, "_rsp_data"}, bus.rsp_data, e[15:0]);
      check({tag, "_busy_resp"}, bus.busy, 1);
   endtask

   task automatic accept(input string tag);
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
      #1;
      check({tag, "_rsp_dropped"}, bus.rsp_valid, 0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      silent = 1'b0;
      spur   = 1'b0;
      bus.req_valid    = '0;
      bus.req_dividend = '0;
      bus.req_divisor  = '0;
      bus.req_mode     = '0;
      bus.rsp_ready    = 1'b0;
      repeat (2) step();

      // Reset state with every requester asking
      bus.req_valid = 4'b1111;
      #1;
      check("rst_req_ready", bus.req_ready, 4'b0000);
      check("rst_busy", bus.busy, 0);
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_div_valid_input", bus.div_valid_input, 0);
      check("rst_div_reset", bus.div_reset, 1);
      check("rst_rsp_data", bus.rsp_data, 0);
      check("rst_div_dividend", bus.div_dividend, 0);
      check("rst_fsm_state", bus.fsm_state, 0);
      bus.req_valid = '0;
      reset = 1'b0;
      step();
      check("idle_div_reset", bus.div_reset, 0);

      // 1: req0 100/7 quotient
      set_req(0, 16'd100, 16'd7, 1'b0);
      exp_q.push_back({1'b0, 2'd0, 16'd14});
      bus.req_valid = 4'b0001;
      #1;
      check("t1_req_ready", bus.req_ready, 4'b0001);
      step();
      bus.req_valid = '0;
      #1;
      check("t1_issue_pulse", bus.div_valid_input, 1);
      check("t1_div_dividend", bus.div_dividend, 100);
      check("t1_div_divisor", bus.div_divisor, 7);
      check("t1_div_mode", bus.div_mode, 0);
      finish_op("t1", 1);
      accept("t1");
      check("t1_idle_busy", bus.busy, 0);

      // 2: req2 100/7 remainder
      set_req(2, 16'd100, 16'd7, 1'b1);
      exp_q.push_back({1'b0, 2'd2, 16'd2});
      bus.req_valid = 4'b0100;
      #1;
      check("t2_req_ready", bus.req_ready, 4'b0100);
      check("t2_busy_at_grant", bus.busy, 0);
      step();
      bus.req_valid = '0;
      check("t2_busy_issue", bus.busy, 1);
      finish_op("t2", 1);
      accept("t2");
      check("t2_busy_after", bus.busy, 0);

      // 3: all requesters held for 8 operations, starting fresh from reset
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         set_req(i, 16'(100 + i), 16'(3 + i), (i % 2) == 1);
      end
      bus.req_valid = 4'b1111;
      for (int op = 0; op < 8; op++) begin
         #1;
         check("t3_grant", bus.req_ready, 4'b0001 << (op % 4));
         exp_q.push_back({1'b0, 2'(op % 4), t3_data[op % 4]});
         step();
         finish_op("t3", 1);
         if (op == 7) bus.req_valid = '0;
         accept("t3");
      end

      // 4: req1 divide by zero
      set_req(1, 16'd55, 16'd0, 1'b0);
      exp_q.push_back({1'b1, 2'd1, 16'hFFFF});
      bus.req_valid = 4'b0010;
      #1;
      check("t4_req_ready", bus.req_ready, 4'b0010);
      step();
      bus.req_valid = '0;
      check("t4_rsp_valid_t1", bus.rsp_valid, 1);
      check("t4_no_start", bus.div_valid_input, 0);
      finish_op("t4", 0);
      accept("t4");

      // 5: back-pressure on the response, stray strobe, req0 waiting meanwhile
      set_req(3, 16'd200, 16'd9, 1'b0);
      set_req(0, 16'd9, 16'd2, 1'b0);
      exp_q.push_back({1'b0, 2'd3, 16'd22});
      bus.req_valid = 4'b1000;
      #1;
      check("t5_req_ready", bus.req_ready, 4'b1000);
      step();
      bus.req_valid = 4'b0001;
      finish_op("t5", 1);
      for (int c = 0; c < 5; c++) begin
         spur = (c == 1);
         #1;
         check("t5_hold_valid", bus.rsp_valid, 1);
         check("t5_hold_data", bus.rsp_data, 22);
         check("t5_hold_id", bus.rsp_id, 3);
         check("t5_hold_no_grant", bus.req_ready, 4'b0000);
         step();
      end
      spur = 1'b0;
      bus.rsp_ready = 1'b1;
      #1;
      check("t5_no_grant_on_accept", bus.req_ready, 4'b0000);
      step();
      bus.rsp_ready = 1'b0;
      #1;
      check("t5_idle_after_accept", bus.busy, 0);
      check("t5_req0_grant", bus.req_ready, 4'b0001);
      exp_q.push_back({1'b0, 2'd0, 16'd4});
      step();
      bus.req_valid = '0;
      finish_op("t5b", 1);
      accept("t5b");

      // 6: reset while waiting on the divider
      set_req(2, 16'd50, 16'd5, 1'b0);
      bus.req_valid = 4'b0100;
      #1;
      check("t6_req_ready", bus.req_ready, 4'b0100);
      step();
      bus.req_valid = '0;
      repeat (2) step();
      check("t6_busy_wait", bus.busy, 1);
      reset = 1'b1;
      bus.req_valid = 4'b1111;
      step();
      #1;
      check("t6_busy_cleared", bus.busy, 0);
      check("t6_rsp_valid_cleared", bus.rsp_valid, 0);
      check("t6_req_ready_in_reset", bus.req_ready, 4'b0000);
      check("t6_div_reset", bus.div_reset, 1);
      reset = 1'b0;
      #1;
      check("t6_req0_priority", bus.req_ready, 4'b0001);
      bus.req_valid = '0;
      begin
         int seen = 0;
         for (int c = 0; c < 12; c++) begin
            step();
            if (bus.rsp_valid) seen++;
         end
         check("t6_no_rsp_after_abort", seen, 0);
      end

`ifdef DIV_ARB_TIMEOUT_EN
      // Watchdog with a silent divider
      silent = 1'b1;
      set_req(0, 16'd10, 16'd3, 1'b0);
      exp_q.push_back({1'b1, 2'd0, 16'd0});
      step();
      bus.req_valid = 4'b0001;
      #1;
      check("to_req_ready", bus.req_ready, 4'b0001);
      step();
      bus.req_valid = '0;
      begin
         int n = 0;
         int waitc = 0;
         int rstp = 0;
         while (!bus.rsp_valid && n < 300) begin
            if (bus.busy && !bus.div_valid_input) waitc++;
            if (bus.div_reset) rstp++;
            step();
            n++;
         end
         check("to_wait_cycles", waitc, 64);
         check("to_div_reset_pulses", rstp, 1);
      end
      finish_op("to", 0);
      accept("to");
      silent = 1'b0;
`endif

      check("end_scoreboard_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
